// File: rtl/register_file_scoreboard_pkg.sv
// rtl/register_file_scoreboard_pkg.sv - shared constants and helpers for the register file scoreboard
// Contents: DEF_WIDTH / DEF_INDEX_BITS defaults and pending_count_width().
// Optional feature macro used by this slice: REGISTER_FILE_BYPASS_EN.
package register_file_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_INDEX_BITS = 2;

  // pending_count must hold 0..DEPTH inclusive, so it needs one bit more than the index.
  function automatic int pending_count_width(input int index_bits);
    return index_bits + 1;
  endfunction

endpackage

// File: rtl/register_file_scoreboard_if.sv
// rtl/register_file_scoreboard_if.sv - decode/writeback bus of the register file scoreboard
// master: drives read indices, write and reserve requests; receives read data/ready and pending_count.
// slave : the register file side of the same signals.
interface register_file_scoreboard_if
  import register_file_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS
);

  logic [INDEX_BITS-1:0]                          read_index_a;
  logic [WIDTH-1:0]                               read_data_a;
  logic                                           read_ready_a;
  logic [INDEX_BITS-1:0]                          read_index_b;
  logic [WIDTH-1:0]                               read_data_b;
  logic                                           read_ready_b;
  logic                                           write_enable;
  logic [INDEX_BITS-1:0]                          write_index;
  logic [WIDTH-1:0]                               write_data;
  logic                                           reserve_enable;
  logic [INDEX_BITS-1:0]                          reserve_index;
  logic [pending_count_width(INDEX_BITS)-1:0]     pending_count;

  modport master (
    output read_index_a, read_index_b, write_enable, write_index, write_data,
           reserve_enable, reserve_index,
    input  read_data_a, read_ready_a, read_data_b, read_ready_b, pending_count
  );

  modport slave (
    input  read_index_a, read_index_b, write_enable, write_index, write_data,
           reserve_enable, reserve_index,
    output read_data_a, read_ready_a, read_data_b, read_ready_b, pending_count
  );

endinterface

// File: rtl/register_file_scoreboard_read_port.sv
// rtl/register_file_scoreboard_read_port.sv - one combinational read port (module register_file_read_port)
// Ports: i_reset forces idle outputs; i_index selects from i_regs/i_pending; o_data/o_ready result.
// With REGISTER_FILE_BYPASS_EN: i_write_enable/i_write_index/i_write_data forward an in-flight write.
module register_file_read_port #(
  parameter int WIDTH      = 16,
  parameter int INDEX_BITS = 2,
  parameter int DEPTH      = 4
) (
  input  logic                        i_reset,
  input  logic [INDEX_BITS-1:0]       i_index,
  input  logic [DEPTH-1:0][WIDTH-1:0] i_regs,
  input  logic [DEPTH-1:0]            i_pending,
`ifdef REGISTER_FILE_BYPASS_EN
  input  logic                        i_write_enable,
  input  logic [INDEX_BITS-1:0]       i_write_index,
  input  logic [WIDTH-1:0]            i_write_data,
`endif
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_ready
);

  always_comb begin
    o_data  = i_regs[i_index];
    o_ready = !i_pending[i_index];
`ifdef REGISTER_FILE_BYPASS_EN
    // A write landing on this index this cycle completes the register, so any
    // same-cycle reservation is deliberately ignored for the forwarded ready.
    if (i_write_enable && (i_write_index == i_index)) begin
      o_data  = i_write_data;
      o_ready = 1'b1;
    end
`else
`endif
    // Reset wins over forwarding so the port looks idle while reset is held.
    if (i_reset) begin
      o_data  = '0;
      o_ready = 1'b1;
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// rtl/register_file_scoreboard.sv - 2R/1W register file with per-register pending scoreboard
// Ports: clk, reset (async, active-high), bus (register_file_scoreboard_if.slave).
// Optional: REGISTER_FILE_BYPASS_EN forwards same-cycle writes to the read ports.
module register_file_scoreboard
  import register_file_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int INDEX_BITS = DEF_INDEX_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  register_file_scoreboard_if.slave     bus
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int CW    = pending_count_width(INDEX_BITS);

  logic [DEPTH-1:0][WIDTH-1:0] r_regs;
  logic [DEPTH-1:0]            r_pending;
  logic [CW-1:0]               r_count;

  logic [DEPTH-1:0]            w_pending_next;
  logic [CW-1:0]               w_count_next;

  // Reserve is applied after write so a same-index collision ends pending.
  always_comb begin
    w_pending_next = r_pending;
    if (bus.write_enable)   w_pending_next[bus.write_index]   = 1'b0;
    if (bus.reserve_enable) w_pending_next[bus.reserve_index] = 1'b1;
  end

  // Count is recomputed from the next bit vector, so it can never drift or wrap.
  always_comb begin
    w_count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count_next = w_count_next + CW'(w_pending_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regs    <= '0;
      r_pending <= '0;
      r_count   <= '0;
    end else begin
      if (bus.write_enable) r_regs[bus.write_index] <= bus.write_data;
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
    end
  end

  assign bus.pending_count = r_count;

  register_file_read_port #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS), .DEPTH(DEPTH)) u_port_a (
    .i_reset        (reset),
    .i_index        (bus.read_index_a),
    .i_regs         (r_regs),
    .i_pending      (r_pending),
`ifdef REGISTER_FILE_BYPASS_EN
    .i_write_enable (bus.write_enable),
    .i_write_index  (bus.write_index),
    .i_write_data   (bus.write_data),
`endif
    .o_data         (bus.read_data_a),
    .o_ready        (bus.read_ready_a)
  );

  register_file_read_port #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS), .DEPTH(DEPTH)) u_port_b (
    .i_reset        (reset),
    .i_index        (bus.read_index_b),
    .i_regs         (r_regs),
    .i_pending      (r_pending),
`ifdef REGISTER_FILE_BYPASS_EN
    .i_write_enable (bus.write_enable),
    .i_write_index  (bus.write_index),
    .i_write_data   (bus.write_data),
`endif
    .o_data         (bus.read_data_b),
    .o_ready        (bus.read_ready_b)
  );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// tb/tb_register_file_scoreboard.sv - scoreboard bench for register_file_scoreboard
module tb_register_file_scoreboard;

  localparam int WIDTH      = 16;
  localparam int INDEX_BITS = 2;
  localparam int DEPTH      = 4;

  typedef struct {
    string tag;
    int    data_a;
    int    ready_a;
    int    data_b;
    int    ready_b;
    int    count;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  register_file_scoreboard_if #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) bus_if ();

  register_file_scoreboard #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // Reference model: plain arrays updated with the architectural rules.
  int   m_regs [DEPTH];
  bit   m_pend [DEPTH];
  exp_t exp_q  [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = 0;
      m_pend[i] = 0;
    end
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic void model_read(input int idx, output int d, output int r);
    if (reset) begin
      d = 0; r = 1;
      return;
    end
    d = m_regs[idx];
    r = m_pend[idx] ? 0 : 1;
`ifdef REGISTER_FILE_BYPASS_EN
    if (bus_if.write_enable && int'(bus_if.write_index) == idx) begin
      d = int'(bus_if.write_data);
      r = 1;
    end
`endif
  endfunction

  task automatic push_expect(input string tag);
    exp_t e;
    e.tag = tag;
    model_read(int'(bus_if.read_index_a), e.data_a, e.ready_a);
    model_read(int'(bus_if.read_index_b), e.data_b, e.ready_b);
    e.count = reset ? 0 : model_count();
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus (just after a rising edge), log the expected
  // pre-edge view, then commit the same request into the model at the edge.
  task automatic step(input string tag, input int ra, input int rb,
                      input bit we, input int wi, input int wd,
                      input bit re, input int ri);
    bus_if.read_index_a   = INDEX_BITS'(ra);
    bus_if.read_index_b   = INDEX_BITS'(rb);
    bus_if.write_enable   = we;
    bus_if.write_index    = INDEX_BITS'(wi);
    bus_if.write_data     = WIDTH'(wd);
    bus_if.reserve_enable = re;
    bus_if.reserve_index  = INDEX_BITS'(ri);
    push_expect(tag);
    @(posedge clk);
    if (reset) model_clear();
    else begin
      if (we) begin
        m_regs[wi] = wd & 16'hFFFF;
        m_pend[wi] = 0;
      end
      if (re) m_pend[ri] = 1;
    end
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares on the falling edge, well away from the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".data_a"},  int'(bus_if.read_data_a),   e.data_a);
        chk({e.tag, ".ready_a"}, int'(bus_if.read_ready_a),  e.ready_a);
        chk({e.tag, ".data_b"},  int'(bus_if.read_data_b),   e.data_b);
        chk({e.tag, ".ready_b"}, int'(bus_if.read_ready_b),  e.ready_b);
        chk({e.tag, ".count"},   int'(bus_if.pending_count), e.count);
      end
    end
  end

  initial begin
    int guard;
    model_clear();
    bus_if.read_index_a = '0; bus_if.read_index_b = '0;
    bus_if.write_enable = 1'b0; bus_if.write_index = '0; bus_if.write_data = '0;
    bus_if.reserve_enable = 1'b0; bus_if.reserve_index = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step("in_reset", 0, 3, 1, 1, 16'hAAAA, 1, 1);
    reset = 1'b0;

    step("after_reset", 0, 3, 0, 0, 0, 0, 0);
    step("wr_r0",       0, 1, 1, 0, 3, 0, 0);
    step("wr_r1",       0, 1, 1, 1, 7, 0, 0);
    step("we_low",      0, 1, 0, 0, 10, 0, 0);
    step("rd_r0_r1",    0, 1, 0, 0, 0, 0, 0);
    step("rsv_r2",      2, 2, 0, 0, 0, 1, 2);
    step("r2_pending",  2, 0, 0, 0, 0, 0, 0);
    step("wr_r2",       2, 2, 1, 2, 16'h55AA, 0, 0);
    step("r2_done",     2, 2, 0, 0, 0, 0, 0);
    step("wr_rsv_r3",   3, 0, 1, 3, 16'hBEEF, 1, 3);
    step("r3_pending",  3, 0, 0, 0, 0, 0, 0);
    step("rsv0_wr3",    0, 3, 1, 3, 16'h0009, 1, 0);
    step("r0p_r3r",     0, 3, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step("rsv_all", i, 3 - i, 0, 0, 0, 1, i);
    step("all_pending", 1, 2, 0, 0, 0, 0, 0);
    // Reset between edges: outputs must clear before the next rising edge.
    reset = 1'b1;
    step("mid_reset", 1, 3, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step("post_reset",  1, 3, 0, 0, 0, 0, 0);
    step("pre_bypass",  1, 1, 1, 1, 16'h1111, 0, 0);
    step("bypass_wr",   1, 0, 1, 1, 16'h1234, 1, 1);
    step("bypass_after",1, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      step("rand",
           $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 16'hFFFF),
           $urandom_range(0, 1), $urandom_range(0, DEPTH - 1));
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
